// File: rtl/axi4_lite_reg_bridge.sv
// axi4_lite_reg_bridge
// Bridges an AXI4-Lite slave port onto a simple single-cycle register bus.
// Only one transaction is in flight at a time. A write needs both AW and W
// (in any order); a read needs AR. When a write and a read compete in IDLE,
// the pri bit selects the winner and then favours the other direction next.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   aw*/w*/b*              AXI4-Lite write address, write data, write response
//   ar*/r*                 AXI4-Lite read address, read data/response
//   reg_wen, reg_ren       one-cycle register write / read strobes
//   reg_addr               captured word address (bits [1:0] forced to 0)
//   reg_wdata, reg_wstrb   captured write data and byte strobes
//   reg_rdata, reg_err     register read data and access error, both sampled
//                          in the strobe cycle
module axi4_lite_reg_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    reg_wen,
    output logic                    reg_ren,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic                    pri_q, pri_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;

    logic aw_hs, w_hs, ar_hs;
    logic nothing_held, contend;

    // Protection bits are accepted but carry no meaning here; the low address
    // bits are dropped because the register bus is word addressed.
    logic unused_inputs;
    assign unused_inputs = ^{awprot, arprot, addr_q[1:0]};

    assign nothing_held = !aw_held_q && !w_held_q;
    // Arbitration only matters when a read competes with a write that has not
    // started yet; a partially received write always completes first.
    assign contend      = nothing_held && arvalid && (awvalid || wvalid);

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        pri_d     = pri_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready   = 1'b0;
        wready    = 1'b0;
        arready   = 1'b0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
        reg_wen   = 1'b0;
        reg_ren   = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        ar_hs     = 1'b0;

        unique case (state_q)
            S_RST: state_d = S_IDLE;
            S_IDLE: begin
                awready = !aw_held_q && !(contend && pri_q);
                wready  = !w_held_q && !(contend && pri_q);
                arready = nothing_held && !(contend && !pri_q);
                aw_hs   = awvalid && awready;
                w_hs    = wvalid && wready;
                ar_hs   = arvalid && arready;
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    addr_d    = awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    state_d = S_WRITE;
                end else if (ar_hs) begin
                    addr_d  = araddr;
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                reg_wen = 1'b1;
                err_d   = reg_err;
                state_d = S_WRESP;
            end
            S_WRESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    pri_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_READ: begin
                reg_ren = 1'b1;
                err_d   = reg_err;
                rdata_d = reg_rdata;
                state_d = S_RRESP;
            end
            S_RRESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    pri_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_RST;
        endcase
    end

    // Control state: cleared by reset so an interrupted transaction is dropped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_RST;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            pri_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            pri_q     <= pri_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Captured payload: only consumed behind the held flags / state, so no reset.
    always_ff @(posedge aclk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    assign bresp     = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign rresp     = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign rdata     = rdata_q;
    assign reg_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign reg_wdata = wdata_q;
    assign reg_wstrb = wstrb_q;

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Testbench for axi4_lite_reg_bridge: directed vector table, hand-written
// multi-cycle sequences (W before AW, stalled read response, continuous
// read/write contention, reset during a write response) and random traffic
// against a register-array model of the attached register file.
module tb_axi4_lite_reg_bridge;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] awaddr, araddr, reg_addr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata, reg_wdata, reg_rdata;
    logic [3:0]    wstrb, reg_wstrb;
    logic [1:0]    bresp, rresp;
    logic          reg_wen, reg_ren, reg_err;

    always #5 aclk = ~aclk;

    axi4_lite_reg_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file attached to the bus: words at or above 0xC00 report an error.
    logic [DW-1:0] slv_mem [0:1023];
    logic [DW-1:0] model   [0:1023];
    logic          mem_init;
    logic          err_force;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign reg_rdata = slv_mem[reg_addr[AW-1:2]];
    assign reg_err   = err_force | (reg_addr >= 12'hC00);

    always @(posedge aclk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) slv_mem[i] <= init_val(i);
        end else if (reg_wen && !reg_err) begin
            for (int b = 0; b < 4; b++)
                if (reg_wstrb[b]) slv_mem[reg_addr[AW-1:2]][8*b +: 8] <= reg_wdata[8*b +: 8];
        end
    end

    // Strobe monitor
    int         wen_cnt = 0;
    int         ren_cnt = 0;
    bit         log_en  = 1'b0;
    logic [7:0] strobe_log [$];

    always @(negedge aclk) begin
        if (reg_wen || reg_ren) begin
            chk("single_strobe", 64'(reg_wen & reg_ren), 64'd0);
            if (reg_wen) wen_cnt++;
            if (reg_ren) ren_cnt++;
            if (log_en) strobe_log.push_back(reg_wen ? 8'h57 : 8'h52);
        end
    end

    task automatic align();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_aw(input logic [AW-1:0] a, input int dly);
        int n;
        repeat (dly) align();
        awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < 40) begin @(negedge aclk); n++; end
        chk("aw_handshake", 64'(awready), 64'd1);
        align();
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        repeat (dly) align();
        wdata = d; wstrb = s; wvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!wready && n < 40) begin @(negedge aclk); n++; end
        chk("w_handshake", 64'(wready), 64'd1);
        align();
        wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [AW-1:0] a, input int dly);
        int n;
        repeat (dly) align();
        araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 40) begin @(negedge aclk); n++; end
        chk("ar_handshake", 64'(arready), 64'd1);
        align();
        arvalid = 1'b0;
    endtask

    // Starts one edge after the last of AW/W was accepted.
    task automatic write_tail(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int db, input logic exp_err, input int wen0);
        logic [AW-1:0] ea;
        logic [63:0]   er;
        ea = {a[AW-1:2], 2'b00};
        er = exp_err ? 64'd2 : 64'd0;
        @(negedge aclk);
        chk("wen_strobe", 64'(reg_wen), 64'd1);
        chk("wen_addr", 64'(reg_addr), 64'(ea));
        chk("wen_data", 64'(reg_wdata), 64'(d));
        chk("wen_strb", 64'(reg_wstrb), 64'(s));
        @(negedge aclk);
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        chk("bresp", 64'(bresp), er);
        for (int i = 0; i < db; i++) begin
            @(negedge aclk);
            chk("bvalid_hold", 64'(bvalid), 64'd1);
            chk("bresp_hold", 64'(bresp), er);
        end
        bready = 1'b1;
        align();
        bready = 1'b0;
        chk("bvalid_clear", 64'(bvalid), 64'd0);
        chk("wen_count", 64'(wen_cnt - wen0), 64'd1);
        if (!exp_err) model[ea[AW-1:2]] = merge(model[ea[AW-1:2]], d, s);
    endtask

    task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int da, input int dw, input int db, input logic exp_err);
        int wen0;
        wen0 = wen_cnt;
        fork
            drive_aw(a, da);
            drive_w(d, s, dw);
        join
        write_tail(a, d, s, db, exp_err, wen0);
    endtask

    task automatic read_txn(input logic [AW-1:0] a, input int da, input int dr,
                            input logic [31:0] exp_d, input logic exp_err);
        int          ren0;
        logic [63:0] er;
        ren0 = ren_cnt;
        er   = exp_err ? 64'd2 : 64'd0;
        drive_ar(a, da);
        @(negedge aclk);
        chk("ren_strobe", 64'(reg_ren), 64'd1);
        chk("ren_addr", 64'(reg_addr), 64'({a[AW-1:2], 2'b00}));
        @(negedge aclk);
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        chk("rdata", 64'(rdata), 64'(exp_d));
        chk("rresp", 64'(rresp), er);
        for (int i = 0; i < dr; i++) begin
            @(negedge aclk);
            chk("rvalid_hold", 64'(rvalid), 64'd1);
            chk("rdata_hold", 64'(rdata), 64'(exp_d));
            chk("rresp_hold", 64'(rresp), er);
        end
        rready = 1'b1;
        align();
        rready = 1'b0;
        chk("rvalid_clear", 64'(rvalid), 64'd0);
        chk("ren_count", 64'(ren_cnt - ren0), 64'd1);
    endtask

    typedef struct {
        bit          is_read;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          da;
        int          dw;
        int          dr;
        bit          force_err;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [0:NV-1];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wen0;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          rd;
        bit          er;

        //        rd    addr     data           strb  da dw dr  frc  exp_rdata      err
        vecs[0] = '{1'b0, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 12'h010, 32'h0,        4'h0, 1, 0, 2, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 12'h014, 32'h11223344, 4'hF, 2, 0, 1, 1'b0, 32'h0,        1'b0};
        vecs[3] = '{1'b0, 12'h016, 32'h0000CAFE, 4'h3, 0, 2, 0, 1'b0, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 12'h014, 32'h0,        4'h0, 0, 0, 0, 1'b0, 32'h1122CAFE, 1'b0};
        vecs[5] = '{1'b0, 12'hC04, 32'hFFFFFFFF, 4'hF, 1, 1, 0, 1'b0, 32'h0,        1'b1};
        vecs[6] = '{1'b1, 12'hC08, 32'h0,        4'h0, 0, 0, 1, 1'b0, init_val(770), 1'b1};
        vecs[7] = '{1'b0, 12'h008, 32'h12345678, 4'hF, 0, 0, 0, 1'b0, 32'h0,        1'b0};
        vecs[8] = '{1'b1, 12'h008, 32'h0,        4'h0, 0, 0, 4, 1'b1, 32'h12345678, 1'b1};
        vecs[9] = '{1'b1, 12'h008, 32'h0,        4'h0, 0, 0, 0, 1'b0, 32'h12345678, 1'b0};

        aresetn = 1'b0; mem_init = 1'b1; err_force = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 1024; i++) model[i] = init_val(i);
        repeat (3) @(posedge aclk);
        #1 mem_init = 1'b0;

        // Reset state
        @(negedge aclk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_reg_wen", 64'(reg_wen), 64'd0);
        chk("rst_reg_ren", 64'(reg_ren), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        aresetn = 1'b1;
        #1 chk("rst_state_awready", 64'(awready), 64'd0);
        @(negedge aclk);
        chk("idle_awready", 64'(awready), 64'd1);
        chk("idle_wready", 64'(wready), 64'd1);
        chk("idle_arready", 64'(arready), 64'd1);
        align();

        // Directed vector table
        for (int v = 0; v < NV; v++) begin
            err_force = vecs[v].force_err;
            if (vecs[v].is_read)
                read_txn(vecs[v].addr, vecs[v].da, vecs[v].dr, vecs[v].exp_rdata, vecs[v].exp_err);
            else
                write_txn(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].da, vecs[v].dw,
                          vecs[v].dr, vecs[v].exp_err);
            err_force = 1'b0;
        end

        // W accepted three cycles before AW; unaligned address 0x23
        wen0 = wen_cnt;
        drive_w(32'hA5A5_5A5A, 4'hF, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("wready_dropped", 64'(wready), 64'd0);
            chk("awready_open", 64'(awready), 64'd1);
            chk("no_early_wen", 64'(reg_wen), 64'd0);
        end
        align();
        drive_aw(12'h023, 0);
        write_tail(12'h023, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, wen0);
        read_txn(12'h020, 0, 0, 32'hA5A5_5A5A, 1'b0);

        // Continuous read and write requests from reset: alternate W, R, W, ...
        @(negedge aclk);
        aresetn = 1'b0;
        awaddr = 12'hC40; araddr = 12'hC40; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        chk("rst_arready_contend", 64'(arready), 64'd0);
        chk("rst_awready_contend", 64'(awready), 64'd0);
        strobe_log.delete();
        log_en  = 1'b1;
        aresetn = 1'b1;
        repeat (30) @(negedge aclk);
        log_en = 1'b0;
        chk("arb_strobe_count", 64'(strobe_log.size() >= 8), 64'd1);
        foreach (strobe_log[i])
            chk("arb_order", 64'(strobe_log[i]), (i % 2 == 0) ? 64'h57 : 64'h52);
        aresetn = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        align();

        // Reset asserted while the write response is pending
        wen0 = wen_cnt;
        fork
            drive_aw(12'h030, 0);
            drive_w(32'h7777_8888, 4'hF, 0);
        join
        @(negedge aclk);
        chk("abort_wen", 64'(reg_wen), 64'd1);
        @(negedge aclk);
        chk("abort_bvalid_before", 64'(bvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("abort_bvalid_async", 64'(bvalid), 64'd0);
        chk("abort_wready", 64'(wready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1 chk("abort_release_awready", 64'(awready), 64'd0);
        @(negedge aclk);
        chk("abort_post_awready", 64'(awready), 64'd1);
        chk("abort_no_extra_wen", 64'(wen_cnt - wen0), 64'd1);
        chk("abort_no_bvalid", 64'(bvalid), 64'd0);
        model[12] = 32'h7777_8888;
        align();
        write_txn(12'h030, 32'h1234_ABCD, 4'b1100, 0, 0, 0, 1'b0);
        read_txn(12'h030, 0, 0, 32'h1234_8888, 1'b0);

        // Random traffic against the register-array model
        for (int k = 0; k < 60; k++) begin
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 12'hC00 | 12'($urandom_range(0, 63));
            else                           a = 12'($urandom_range(0, 63));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            er = (a >= 12'hC00);
            if (rd)
                read_txn(a, $urandom_range(0, 2), $urandom_range(0, 3), model[a[AW-1:2]], er);
            else
                write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_bridge.md
AXI4_LITE_REG_BRIDGE -- requirements
Module: axi4_lite_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte address width of both AXI4-Lite and register-bus addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 supported; WSTRB width = DATA_WIDTH/8.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 aclk  in  1  sole clock; all state rising-edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 awaddr  in  ADDR_WIDTH  write address.
REQ-007 awprot  in  axi4::prot_t  write protection; accepted, ignored.
REQ-008 awvalid / awready  in / out  1 each  AW handshake.
REQ-009 wdata  in  DATA_WIDTH  write data.
REQ-010 wstrb  in  DATA_WIDTH/8  byte enables.
REQ-011 wvalid / wready  in / out  1 each  W handshake.
REQ-012 bresp  out  axi4::resp_t  write response.
REQ-013 bvalid / bready  out / in  1 each  B handshake.
REQ-014 araddr  in  ADDR_WIDTH  read address.
REQ-015 arprot  in  axi4::prot_t  read protection; accepted, ignored.
REQ-016 arvalid / arready  in / out  1 each  AR handshake.
REQ-017 rdata  out  DATA_WIDTH  read data.
REQ-018 rresp  out  axi4::resp_t  read response.
REQ-019 rvalid / rready  out / in  1 each  R handshake.
REQ-020 reg_wen / reg_ren  out  1 each  one-cycle register write / read strobes; never both high.
REQ-021 reg_addr  out  ADDR_WIDTH  captured address, bits [1:0] forced 0.
REQ-022 reg_wdata / reg_wstrb  out  DATA_WIDTH / DATA_WIDTH/8  captured write data and strobes.
REQ-023 reg_rdata  in  DATA_WIDTH  read data, valid combinationally in the reg_ren cycle.
REQ-024 reg_err  in  1  access error, sampled in the reg_wen/reg_ren cycle.

Function
REQ-025 SHALL implement states RST, IDLE, WRITE, WRESP, READ, RRESP; RST -> IDLE unconditionally on the first aclk edge after reset release.
REQ-026 In IDLE, awready = !aw_held and wready = !w_held, each gated by arbitration (REQ-028); a completed AW or W handshake SHALL set aw_held or w_held and register the channel payload; AW and W may arrive in either order or in the same cycle.
REQ-027 In IDLE, arready SHALL be 1 only if aw_held = w_held = 0 and arbitration selects read; an AR handshake SHALL register araddr and transition to READ.
REQ-028 Arbitration bit pri, reset 0: with nothing held, arvalid = 1 and (awvalid or wvalid) = 1 -> pri = 0 selects write (arready = 0), pri = 1 selects read (awready = wready = 0); pri SHALL be set to 1 on B completion and 0 on R completion.
REQ-029 IDLE -> WRITE on the edge where both held flags are, or become, 1; WRITE: reg_wen = 1 for exactly one cycle; capture reg_err; -> WRESP.
REQ-030 WRESP: bvalid = 1, bresp = 2'b10 (SLVERR) if the captured err = 1, else 2'b00 (OKAY); held stable until bready; on handshake clear held flags -> IDLE.
REQ-031 READ: reg_ren = 1 for exactly one cycle; register reg_rdata and reg_err -> RRESP; RRESP: rvalid = 1, rdata stable, rresp = SLVERR/OKAY as REQ-030; on rready -> IDLE.
REQ-032 Latency: AW+W or AR handshake at edge N -> strobe in cycle N+1 -> bvalid/rvalid at edge N+2; back-to-back throughput = one transaction per 3 cycles minimum.
REQ-033 All ready signals SHALL be 0 in WRITE, WRESP, READ, RRESP, RST; at most one outstanding transaction; valid SHALL never depend on ready.

Reset
REQ-034 While aresetn = 0: state = RST, all readys, bvalid, rvalid, reg_wen, reg_ren = 0; bresp = rresp = 2'b00; rdata = 0; held flags = 0; pri = 0; reset mid-transaction SHALL abandon it without issuing a strobe or response.

Verification
REQ-035 AW+W same cycle, addr 0x10, data 0xDEADBEEF, wstrb 0xF, bready = 1 -> reg_wen one cycle later with reg_addr 0x10, bvalid two cycles after, bresp OKAY.
REQ-036 W three cycles before AW (addr 0x23) -> wready drops after W; single reg_wen after AW, reg_addr 0x20.
REQ-037 AR 0x8, reg_rdata = 0x12345678, reg_err = 1, rready held 0 for 4 cycles -> rvalid stays 1, rdata 0x12345678, rresp SLVERR stable until rready.
REQ-038 arvalid and awvalid+wvalid asserted continuously from reset -> write first, then read, then write alternating; never two strobes in one cycle.
REQ-039 aresetn pulsed low during WRESP -> bvalid = 0 immediately; no further reg_wen; normal operation from the second edge after release.
